// File: rtl/rv32i_mem_arbiter_if.sv
// rv32i_mem_arbiter_if
// Bundles the fetch port, the data (load/store) port and the single-port
// memory bus that the arbiter sits between. Signal names keep the arbiter's
// point of view: i_* are driven into the arbiter, o_* are driven by it.
// The slave modport is the arbiter's view; the master modport is the view of
// whatever surrounds it (core plus memory, or a testbench).
interface rv32i_mem_arbiter_if #(
    parameter int MEMORY_DEPTH = 8192,
    localparam int AW = $clog2(MEMORY_DEPTH) - 2
);
    // Instruction-fetch port
    logic          i_inst_req;
    logic [31:0]   i_inst_addr;
    logic          o_inst_ack;
    logic [31:0]   o_inst;

    // Data load/store port
    logic          i_data_req;
    logic          i_data_wr_en;
    logic [31:0]   i_data_addr;
    logic [31:0]   i_data_in;
    logic [3:0]    i_data_wr_mask;
    logic          o_data_ack;
    logic [31:0]   o_data_out;
    logic          o_addr_err;

    // Single-port memory side
    logic          o_mem_en;
    logic          o_mem_wr_en;
    logic [AW-1:0] o_mem_addr;
    logic [31:0]   o_mem_din;
    logic [3:0]    o_mem_mask;
    logic [31:0]   i_mem_dout;

    modport slave (
        input  i_inst_req,
        input  i_inst_addr,
        output o_inst_ack,
        output o_inst,
        input  i_data_req,
        input  i_data_wr_en,
        input  i_data_addr,
        input  i_data_in,
        input  i_data_wr_mask,
        output o_data_ack,
        output o_data_out,
        output o_addr_err,
        output o_mem_en,
        output o_mem_wr_en,
        output o_mem_addr,
        output o_mem_din,
        output o_mem_mask,
        input  i_mem_dout
    );

    modport master (
        output i_inst_req,
        output i_inst_addr,
        input  o_inst_ack,
        input  o_inst,
        output i_data_req,
        output i_data_wr_en,
        output i_data_addr,
        output i_data_in,
        output i_data_wr_mask,
        input  o_data_ack,
        input  o_data_out,
        input  o_addr_err,
        input  o_mem_en,
        input  o_mem_wr_en,
        input  o_mem_addr,
        input  o_mem_din,
        input  o_mem_mask,
        output i_mem_dout
    );
endinterface

// File: rtl/rv32i_mem_arbiter.sv
// rv32i_mem_arbiter
// Shares the single-port SoC memory between the core's instruction-fetch port
// and its data port. One access is in flight at a time and walks through
// IDLE -> ISSUE -> WAIT, giving a fixed 3-cycle request-to-ack latency:
//   edge k   : request sampled and latched (grant), memory outputs registered
//   cycle k+1: ISSUE, memory strobe high for exactly this cycle
//   cycle k+2: WAIT, read data from memory captured at the end of the cycle
//   cycle k+3: one-cycle ack for the granted port (arbiter already IDLE)
// Contention is resolved round-robin. Addresses at or beyond MEMORY_DEPTH
// never touch the memory; they complete with zero read data and o_addr_err.
// Build option: define MEM_ARB_DATA_PRIORITY_EN to make the data port always
// win contention instead of round-robin.
module rv32i_mem_arbiter #(
    parameter int MEMORY_DEPTH = 8192,
    localparam int AW = $clog2(MEMORY_DEPTH) - 2
) (
    input  logic               i_clk,
    input  logic               i_rst,
    rv32i_mem_arbiter_if.slave io_bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    typedef enum logic {
        PORT_INST = 1'b0,
        PORT_DATA = 1'b1
    } port_t;

    localparam logic [31:0] DEPTH_BYTES = 32'(MEMORY_DEPTH);

    // FSM state
    state_t        r_state;
    state_t        w_state_next;

    // Request latched at grant; the ports may change freely afterwards
    port_t         r_port;
    logic          r_is_store;
    logic          r_oor;

    // Registered memory-side outputs
    logic          r_mem_en;
    logic          r_mem_wr_en;
    logic [AW-1:0] r_mem_addr;
    logic [31:0]   r_mem_din;
    logic [3:0]    r_mem_mask;

    // Registered port-side responses
    logic          r_inst_ack;
    logic          r_data_ack;
    logic          r_addr_err;
    logic [31:0]   r_inst;
    logic [31:0]   r_data_out;

`ifndef MEM_ARB_DATA_PRIORITY_EN
    // Port that won the most recent grant; contention goes to the other one
    port_t         r_last_grant;
`endif

    // Arbitration
    logic          w_inst_pending;
    logic          w_data_pending;
    logic          w_grant;
    port_t         w_grant_port;

    // Payload of the port being granted this cycle
    logic [31:0]   w_sel_addr;
    logic          w_sel_store;
    logic          w_sel_oor;

    // Byte-offset bits of the addresses play no part in a word access
    logic          w_unused_addr_bits;

    // A port being acked this cycle still shows its old request; masking it
    // keeps the completed access from being granted a second time.
    assign w_inst_pending = io_bus.i_inst_req & ~r_inst_ack;
    assign w_data_pending = io_bus.i_data_req & ~r_data_ack;

    assign w_unused_addr_bits = ^{io_bus.i_inst_addr[1:0], io_bus.i_data_addr[1:0]};

    // Next-state logic and grant decision; grants only happen from IDLE
    always_comb begin
        w_state_next = r_state;
        w_grant      = 1'b0;
        w_grant_port = PORT_INST;

        case (r_state)
            ST_IDLE: begin
                if (w_inst_pending && w_data_pending) begin
                    w_grant = 1'b1;
`ifdef MEM_ARB_DATA_PRIORITY_EN
                    w_grant_port = PORT_DATA;
`else
                    w_grant_port = (r_last_grant == PORT_DATA) ? PORT_INST : PORT_DATA;
`endif
                end else if (w_data_pending) begin
                    w_grant      = 1'b1;
                    w_grant_port = PORT_DATA;
                end else if (w_inst_pending) begin
                    w_grant      = 1'b1;
                    w_grant_port = PORT_INST;
                end

                if (w_grant) begin
                    w_state_next = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                w_state_next = ST_WAIT;
            end
            ST_WAIT: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Select the address and store qualifier of whichever port is being granted
    always_comb begin
        w_sel_addr  = io_bus.i_inst_addr;
        w_sel_store = 1'b0;
        if (w_grant_port == PORT_DATA) begin
            w_sel_addr  = io_bus.i_data_addr;
            w_sel_store = io_bus.i_data_wr_en;
        end
    end

    assign w_sel_oor = (w_sel_addr >= DEPTH_BYTES);

    // FSM state register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

`ifndef MEM_ARB_DATA_PRIORITY_EN
    // Remember the last winner so contention alternates between the ports
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_last_grant <= PORT_DATA;
        end else if (w_grant) begin
            r_last_grant <= w_grant_port;
        end
    end
`endif

    // Latch the granted request so WAIT knows where the result goes
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_port     <= PORT_INST;
            r_is_store <= 1'b0;
            r_oor      <= 1'b0;
        end else if (w_grant) begin
            r_port     <= w_grant_port;
            r_is_store <= w_sel_store;
            r_oor      <= w_sel_oor;
        end
    end

    // Drive the memory bus for the single ISSUE cycle that follows a grant
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_mem_en    <= 1'b0;
            r_mem_wr_en <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_din   <= '0;
            r_mem_mask  <= '0;
        end else if (w_grant) begin
            r_mem_en    <= ~w_sel_oor;
            r_mem_wr_en <= ~w_sel_oor & w_sel_store;
            r_mem_addr  <= w_sel_addr[AW+1:2];
            r_mem_din   <= w_sel_store ? io_bus.i_data_in : 32'h0;
            r_mem_mask  <= w_sel_store ? io_bus.i_data_wr_mask : 4'h0;
        end else begin
            r_mem_en    <= 1'b0;
            r_mem_wr_en <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_din   <= '0;
            r_mem_mask  <= '0;
        end
    end

    // Capture read data at the end of WAIT and raise the granted port's ack
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_inst_ack <= 1'b0;
            r_data_ack <= 1'b0;
            r_addr_err <= 1'b0;
            r_inst     <= '0;
            r_data_out <= '0;
        end else begin
            r_inst_ack <= 1'b0;
            r_data_ack <= 1'b0;
            r_addr_err <= 1'b0;
            if (r_state == ST_WAIT) begin
                r_addr_err <= r_oor;
                if (r_port == PORT_INST) begin
                    r_inst_ack <= 1'b1;
                    r_inst     <= r_oor ? 32'h0 : io_bus.i_mem_dout;
                end else begin
                    r_data_ack <= 1'b1;
                    if (!r_is_store) begin
                        r_data_out <= r_oor ? 32'h0 : io_bus.i_mem_dout;
                    end
                end
            end
        end
    end

    assign io_bus.o_inst_ack  = r_inst_ack;
    assign io_bus.o_inst      = r_inst;
    assign io_bus.o_data_ack  = r_data_ack;
    assign io_bus.o_data_out  = r_data_out;
    assign io_bus.o_addr_err  = r_addr_err;
    assign io_bus.o_mem_en    = r_mem_en;
    assign io_bus.o_mem_wr_en = r_mem_wr_en;
    assign io_bus.o_mem_addr  = r_mem_addr;
    assign io_bus.o_mem_din   = r_mem_din;
    assign io_bus.o_mem_mask  = r_mem_mask;

endmodule
